// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU, one quotient bit per cycle.
// Results stay on quotient/remainder until the next divide completes.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic             div_stall,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] qout_q, qout_d;
  logic [WIDTH-1:0] rout_q, rout_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;

  logic             idle;
  logic             issue;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH:0]   rem_sh, diff;
  logic [WIDTH-1:0] rem_nx, quo_nx;

  assign idle  = (state_q == S_IDLE);
  assign issue = idle & start & ~cancel;

  assign a_abs = (signed_op & dividend[WIDTH-1]) ? -dividend : dividend;
  assign b_abs = (signed_op & divisor[WIDTH-1])  ? -divisor  : divisor;

  // Borrow out of the (WIDTH+1)-bit subtract means rem < divisor.
  assign rem_sh = {rem_q, quo_q[WIDTH-1]};
  assign diff   = rem_sh - {1'b0, dvs_q};
  assign rem_nx = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
  assign quo_nx = {quo_q[WIDTH-2:0], ~diff[WIDTH]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    qout_d  = qout_q;
    rout_d  = rout_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    case (state_q)
      S_IDLE: begin
        if (issue) begin
          negq_d = signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          negr_d = signed_op & dividend[WIDTH-1];
          rem_d  = '0;
          cnt_d  = '0;
          quo_d  = a_abs;
          dvs_d  = b_abs;
          if (divisor == '0) begin
            state_d = S_DONE;
            qout_d  = '1;
            rout_d  = dividend;
          end else begin
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        if (cancel) begin
          state_d = S_IDLE;
        end else begin
          rem_d = rem_nx;
          quo_d = quo_nx;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d = S_DONE;
            qout_d  = negq_q ? -quo_nx : quo_nx;
            rout_d  = negr_q ? -rem_nx : rem_nx;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      qout_q  <= '0;
      rout_q  <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      qout_q  <= qout_d;
      rout_q  <= rout_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
    end
  end

  assign busy      = ~idle;
  assign done      = (state_q == S_DONE);
  assign div_stall = issue | busy;
  assign quotient  = qout_q;
  assign remainder = rout_q;

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: cycle-level reference model with per-cycle compare,
// directed corner cases and randomized traffic with cancel/reset.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic        signed_op = 1'b0;
  logic        cancel = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy, done, div_stall;
  logic [31:0] quotient, remainder;

  int n_chk = 0;
  int n_fail = 0;

  div_unit dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .signed_op (signed_op),
    .dividend  (dividend),
    .divisor   (divisor),
    .cancel    (cancel),
    .busy      (busy),
    .done      (done),
    .div_stall (div_stall),
    .quotient  (quotient),
    .remainder (remainder)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_div(input logic s,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb;
    logic [31:0] q, r;
    if (b == 32'd0) begin
      q = '1;
      r = a;
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {q, r};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: cycles left in the divide, done flag, held results.
  int          m_left = 0;
  logic        m_done = 1'b0;
  logic [31:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;
  logic [63:0] ref_now;

  always_comb ref_now = ref_div(signed_op, dividend, divisor);

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_q    <= '0;
      m_r    <= '0;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (m_left > 0) begin
      if (cancel) begin
        m_left <= 0;
      end else begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_done <= 1'b1;
          m_q    <= p_q;
          m_r    <= p_r;
        end
      end
    end else if (start && !cancel) begin
      p_q <= ref_now[63:32];
      p_r <= ref_now[31:0];
      if (divisor == 32'd0) begin
        m_done <= 1'b1;
        m_q    <= ref_now[63:32];
        m_r    <= ref_now[31:0];
      end else begin
        m_left <= 32;
      end
    end
  end

  always @(negedge clk) begin
    logic eb;
    eb = (m_left > 0) || m_done;
    chk("busy", 32'(busy), 32'(eb));
    chk("done", 32'(done), 32'(m_done));
    chk("stall", 32'(div_stall), 32'(eb || (start && !cancel)));
    chk("quotient", quotient, m_q);
    chk("remainder", remainder, m_r);
  end

  task automatic issue(input logic s, input logic [31:0] a,
                       input logic [31:0] b);
    start     = 1'b1;
    signed_op = s;
    dividend  = a;
    divisor   = b;
    @(negedge clk);
    chk("stall_start", 32'(div_stall), 32'd1);
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (done) begin
        lat = n;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_op(input string nm, input logic s,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er,
                        input int elat);
    int lat;
    issue(s, a, b);
    wait_done(lat);
    chk({nm, "_lat"}, 32'(lat), 32'(elat));
    chk({nm, "_q"}, quotient, eq);
    chk({nm, "_r"}, remainder, er);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk({nm, "_idle"}, 32'(busy), 32'd0);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 6)
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return $urandom % 16;
      3:       return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [63:0] t;
    int lat;

    t = ref_div(1'b0, 32'd100, 32'd7);
    chk("model_divu", t[63:32], 32'd14);
    chk("model_divu_r", t[31:0], 32'd2);
    t = ref_div(1'b1, 32'hFFFF_FFF9, 32'd2);
    chk("model_div_neg", t[63:32], 32'hFFFF_FFFD);
    chk("model_div_neg_r", t[31:0], 32'hFFFF_FFFF);
    t = ref_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("model_ovf", t[63:32], 32'h8000_0000);
    chk("model_ovf_r", t[31:0], 32'd0);

    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_q", quotient, 32'd0);
    chk("rst_r", remainder, 32'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;

    run_op("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33);
    run_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2,
           32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
    run_op("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE,
           32'hFFFF_FFFD, 32'd1, 33);
    run_op("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
           32'h8000_0000, 32'd0, 33);
    run_op("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1,
           32'hFFFF_FFFF, 32'd0, 33);
    run_op("divu_by0", 1'b0, 32'h1234, 32'd0,
           32'hFFFF_FFFF, 32'h1234, 1);
    run_op("div_by0", 1'b1, 32'hFFFF_FFF9, 32'd0,
           32'hFFFF_FFFF, 32'hFFFF_FFF9, 1);

    // Cancel mid-divide keeps the previous result.
    run_op("divu_9_4", 1'b0, 32'd9, 32'd4, 32'd2, 32'd1, 33);
    issue(1'b0, 32'd100, 32'd7);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    cancel = 1'b1;
    @(posedge clk);
    #1;
    cancel = 1'b0;
    #2;
    chk("cancel_busy", 32'(busy), 32'd0);
    chk("cancel_q", quotient, 32'd2);
    chk("cancel_r", remainder, 32'd1);
    issue(1'b0, 32'd100, 32'd7);
    wait_done(lat);
    chk("restart_lat", 32'(lat), 32'd33);
    chk("restart_q", quotient, 32'd14);
    @(posedge clk);
    #1;

    // Reset mid-divide.
    issue(1'b0, 32'd100, 32'd7);
    repeat (14) begin
      @(posedge clk);
      #1;
    end
    rstn = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_q", quotient, 32'd0);
    chk("arst_r", remainder, 32'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;

    // Start while busy is ignored.
    issue(1'b0, 32'd100, 32'd7);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    start    = 1'b1;
    dividend = 32'hFFFF_FFFF;
    divisor  = 32'd1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(lat);
    chk("ign_lat", 32'(lat), 32'd28);
    chk("ign_q", quotient, 32'd14);
    chk("ign_r", remainder, 32'd2);
    @(posedge clk);
    #1;

    for (int i = 0; i < 4000; i++) begin
      rstn      = ($urandom % 600) != 0;
      start     = ($urandom % 3) == 0;
      signed_op = 1'($urandom);
      cancel    = ($urandom % 40) == 0;
      dividend  = pick();
      divisor   = (($urandom % 10) == 0) ? 32'd0 : pick();
      @(posedge clk);
      #1;
    end
    rstn   = 1'b1;
    start  = 1'b0;
    cancel = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
